// File: rtl/lbp_window_fetch.sv
// Read-side sequencer for the LBP datapath: walks every interior 3x3 neighbourhood of a
// row-major gray image, reusing two window columns per horizontal step, and hands each window downstream.
module lbp_window_fetch #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            gray_ready,
  output logic            gray_req,
  output logic [AW-1:0]   gray_addr,
  input  logic [DW-1:0]   gray_data,
  output logic            win_valid,
  input  logic            win_ready,
  output logic [9*DW-1:0] win_data,
  output logic [AW-1:0]   win_addr,
  output logic            done
);

  // Handshake: a window transfers at a rising edge where win_valid & win_ready; win_valid
  // never falls and win_data/win_addr never change until that edge (reset excepted).
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FILL    = 3'd1,
    S_SHIFT   = 3'd2,
    S_PRESENT = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [AW-1:0] W_A    = AW'(IMG_W);
  localparam logic [AW-1:0] ONE_A  = AW'(1);
  localparam logic [AW-1:0] LAST_C = AW'(IMG_W - 2);
  localparam logic [AW-1:0] LAST_R = AW'(IMG_H - 2);

  state_e          state_q, state_d;
  logic [AW-1:0]   r_q, r_d;
  logic [AW-1:0]   c_q, c_d;
  logic [1:0]      row_off_q, row_off_d;
  logic [1:0]      col_off_q, col_off_d;
  logic [AW-1:0]   win_addr_q, win_addr_d;
  logic [DW-1:0]   win_q [9];
  logic [DW-1:0]   win_d [9];

  logic            fetching;
  logic [AW-1:0]   fetch_row;
  logic [AW-1:0]   fetch_col;
  logic [AW-1:0]   ctr_addr;
  logic [3:0]      slice;

  assign fetching  = (state_q == S_FILL) || (state_q == S_SHIFT);
  assign gray_req  = fetching && gray_ready;
  assign win_valid = (state_q == S_PRESENT);
  assign done      = (state_q == S_DONE);
  assign win_addr  = win_addr_q;
  assign ctr_addr  = r_q * W_A + c_q;
  assign slice     = 4'(row_off_q) * 4'd3 + 4'(col_off_q);

  // Address is driven (and frozen) for the whole fetch phase so a gray_ready stall resumes in place.
  always_comb begin
    fetch_row = r_q - ONE_A + AW'(row_off_q);
    fetch_col = c_q - ONE_A + AW'(col_off_q);
    gray_addr = '0;
    if (fetching) begin
      gray_addr = fetch_row * W_A + fetch_col;
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++) begin
      win_data[DW*k +: DW] = win_q[k];
    end
  end

  always_comb begin
    state_d    = state_q;
    r_d        = r_q;
    c_d        = c_q;
    row_off_d  = row_off_q;
    col_off_d  = col_off_q;
    win_addr_d = win_addr_q;
    for (int k = 0; k < 9; k++) begin
      win_d[k] = win_q[k];
    end

    if (gray_req) begin
      for (int k = 0; k < 9; k++) begin
        if (slice == 4'(k)) begin
          win_d[k] = gray_data;
        end
      end
    end

    case (state_q)
      S_IDLE: begin
        if (gray_ready) begin
          state_d   = S_FILL;
          row_off_d = 2'd0;
          col_off_d = 2'd0;
        end
      end
      S_FILL: begin
        if (gray_ready) begin
          if (row_off_q == 2'd2) begin
            row_off_d = 2'd0;
            if (col_off_q == 2'd2) begin
              col_off_d  = 2'd0;
              state_d    = S_PRESENT;
              win_addr_d = ctr_addr;
            end else begin
              col_off_d = col_off_q + 2'd1;
            end
          end else begin
            row_off_d = row_off_q + 2'd1;
          end
        end
      end
      S_SHIFT: begin
        // Only the new right-hand column is fetched; col_off stays at 2.
        if (gray_ready) begin
          if (row_off_q == 2'd2) begin
            row_off_d  = 2'd0;
            state_d    = S_PRESENT;
            win_addr_d = ctr_addr;
          end else begin
            row_off_d = row_off_q + 2'd1;
          end
        end
      end
      S_PRESENT: begin
        if (win_ready) begin
          if (c_q < LAST_C) begin
            c_d       = c_q + ONE_A;
            state_d   = S_SHIFT;
            row_off_d = 2'd0;
            col_off_d = 2'd2;
            win_d[0]  = win_q[1];
            win_d[1]  = win_q[2];
            win_d[3]  = win_q[4];
            win_d[4]  = win_q[5];
            win_d[6]  = win_q[7];
            win_d[7]  = win_q[8];
          end else if (r_q < LAST_R) begin
            c_d       = ONE_A;
            r_d       = r_q + ONE_A;
            state_d   = S_FILL;
            row_off_d = 2'd0;
            col_off_d = 2'd0;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      r_q        <= ONE_A;
      c_q        <= ONE_A;
      row_off_q  <= 2'd0;
      col_off_q  <= 2'd0;
      win_addr_q <= '0;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      row_off_q  <= row_off_d;
      col_off_q  <= col_off_d;
      win_addr_q <= win_addr_d;
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= win_d[k];
      end
    end
  end

endmodule

// File: tb/tb_lbp_window_fetch.sv
// Bench for lbp_window_fetch: directed scenarios plus a full random frame checked
// against a window/read-address model derived from the image scan rules.
module tb_lbp_window_fetch;

  localparam int IMG_W = 128;
  localparam int IMG_H = 128;
  localparam int AW    = 14;
  localparam int DW    = 8;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int WW    = AW + 9 * DW;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            gray_ready = 1'b0;
  logic            gray_req;
  logic [AW-1:0]   gray_addr;
  logic [DW-1:0]   gray_data;
  logic            win_valid;
  logic            win_ready = 1'b0;
  logic [9*DW-1:0] win_data;
  logic [AW-1:0]   win_addr;
  logic            done;

  logic [DW-1:0]   gray_mem [NPIX];
  logic [WW-1:0]   exp_q[$];
  logic [AW-1:0]   exp_rd_q[$];
  int              checks = 0;
  int              errors = 0;

  lbp_window_fetch #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .gray_ready(gray_ready), .gray_req(gray_req),
    .gray_addr(gray_addr), .gray_data(gray_data), .win_valid(win_valid),
    .win_ready(win_ready), .win_data(win_data), .win_addr(win_addr), .done(done)
  );

  assign gray_data = gray_mem[gray_addr];

  always #5 clk = ~clk;

  function automatic logic [9*DW-1:0] model_win(input int r, input int c);
    logic [9*DW-1:0] d;
    for (int k = 0; k < 9; k++) begin
      d[DW*k +: DW] = gray_mem[(r - 1 + k / 3) * IMG_W + (c - 1 + k % 3)];
    end
    return d;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    gray_ready = 1'b0;
    win_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic mem_ramp();
    for (int i = 0; i < NPIX; i++) gray_mem[i] = DW'(i);
  endtask

  task automatic mem_rand();
    for (int i = 0; i < NPIX; i++) gray_mem[i] = DW'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    gray_ready = 1'b0;
    win_ready = 1'b0;
    mem_ramp();
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({gray_req, win_valid, done, gray_addr, win_addr, win_data} !== '0) begin
      errors++;
      $display("FAIL reset_values: got req=%b valid=%b done=%b addr=%0d waddr=%0d data=%h, want all 0",
               gray_req, win_valid, done, gray_addr, win_addr, win_data);
    end
    @(negedge clk);
    reset = 1'b1;
    gray_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (gray_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_prefill: gray_req=%b, want 1", gray_req);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({gray_req, win_valid, done, gray_addr, win_addr} !== '0) begin
      errors++;
      $display("FAIL reset_async: got req=%b valid=%b done=%b addr=%0d waddr=%0d, want all 0",
               gray_req, win_valid, done, gray_addr, win_addr);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (gray_req !== 1'b1 || gray_addr !== '0) begin
      errors++;
      $display("FAIL reset_restart: req=%b addr=%0d, want req=1 addr=0", gray_req, gray_addr);
    end
    gray_ready = 1'b0;
  endtask

  task automatic test_first_window();
    int edges;
    logic [AW-1:0] rd_q[$];
    int exp_a;
    apply_reset();
    mem_ramp();
    gray_ready = 1'b1;
    win_ready = 1'b0;
    edges = 0;
    for (int n = 0; n < 30; n++) begin
      #1;
      if (gray_req) rd_q.push_back(gray_addr);
      if (win_valid) break;
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges != 10 || !win_valid) begin
      errors++;
      $display("FAIL first_latency: valid=%b after %0d edges, want valid=1 after 10", win_valid, edges);
    end
    checks++;
    if (rd_q.size() != 9) begin
      errors++;
      $display("FAIL first_read_count: got %0d reads, want 9", rd_q.size());
    end
    for (int i = 0; i < 9 && i < rd_q.size(); i++) begin
      exp_a = (i % 3) * IMG_W + (i / 3);
      checks++;
      if (rd_q[i] !== AW'(exp_a)) begin
        errors++;
        $display("FAIL first_read_addr[%0d]: got %0d, want %0d", i, rd_q[i], exp_a);
      end
    end
    checks++;
    if (win_addr !== AW'(129)) begin
      errors++;
      $display("FAIL first_win_addr: got %0d, want 129", win_addr);
    end
    checks++;
    if (win_data !== {8'h02, 8'h01, 8'h00, 8'h82, 8'h81, 8'h80, 8'h02, 8'h01, 8'h00}) begin
      errors++;
      $display("FAIL first_win_data: got %h, want 020100828180020100", win_data);
    end
  endtask

  task automatic test_column_step();
    int edges;
    logic [AW-1:0] rd_q[$];
    int exp_a;
    win_ready = 1'b1;
    @(negedge clk);
    win_ready = 1'b0;
    edges = 1;
    for (int n = 0; n < 30; n++) begin
      #1;
      if (gray_req) rd_q.push_back(gray_addr);
      if (win_valid) break;
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges != 4 || rd_q.size() != 3) begin
      errors++;
      $display("FAIL step_timing: %0d edges, %0d reads, want 4 edges, 3 reads", edges, rd_q.size());
    end
    for (int i = 0; i < 3 && i < rd_q.size(); i++) begin
      exp_a = i * IMG_W + 3;
      checks++;
      if (rd_q[i] !== AW'(exp_a)) begin
        errors++;
        $display("FAIL step_read_addr[%0d]: got %0d, want %0d", i, rd_q[i], exp_a);
      end
    end
    checks++;
    if (win_addr !== AW'(130) || win_data[4*DW +: DW] !== 8'h82 || win_data[0 +: DW] !== 8'h01) begin
      errors++;
      $display("FAIL step_window: addr=%0d s4=%h s0=%h, want 130 82 01",
               win_addr, win_data[4*DW +: DW], win_data[0 +: DW]);
    end
    checks++;
    if (win_data !== model_win(1, 2)) begin
      errors++;
      $display("FAIL step_win_data: got %h, want %h", win_data, model_win(1, 2));
    end
  endtask

  task automatic test_backpressure();
    logic [9*DW-1:0] held_d;
    logic [AW-1:0]   held_a;
    held_d = win_data;
    held_a = win_addr;
    win_ready = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      gray_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (win_valid !== 1'b1 || gray_req !== 1'b0 || win_data !== held_d || win_addr !== held_a) begin
        errors++;
        $display("FAIL backpressure[%0d]: valid=%b req=%b addr=%0d data=%h, want 1 0 %0d %h",
                 n, win_valid, gray_req, win_addr, win_data, held_a, held_d);
      end
    end
    gray_ready = 1'b1;
    win_ready = 1'b1;
    @(negedge clk);
    win_ready = 1'b0;
    #1;
    checks++;
    if (win_valid !== 1'b0 || gray_req !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b req=%b, want valid=0 req=1", win_valid, gray_req);
    end
  endtask

  task automatic test_row_wrap_stall();
    logic [AW-1:0] rd_q[$];
    int found, nreads, stall, exp_a;
    found = 0;
    for (int n = 0; n < 1000; n++) begin
      #1;
      if (win_valid && win_addr == AW'(254)) begin
        found = 1;
        break;
      end
      win_ready = win_valid;
      @(negedge clk);
      win_ready = 1'b0;
    end
    checks++;
    if (found == 0 || win_data !== model_win(1, 126)) begin
      errors++;
      $display("FAIL wrap_reach_254: found=%0d data=%h, want found=1 data=%h", found, win_data, model_win(1, 126));
    end
    win_ready = 1'b1;
    @(negedge clk);
    win_ready = 1'b0;
    nreads = 0;
    stall = 0;
    for (int n = 0; n < 40; n++) begin
      gray_ready = !(nreads == 4 && stall < 5);
      if (!gray_ready) stall++;
      #1;
      if (!gray_ready) begin
        exp_a = 1 * IMG_W + 1 + IMG_W;
        checks++;
        if (gray_req !== 1'b0 || gray_addr !== AW'(exp_a)) begin
          errors++;
          $display("FAIL stall_freeze: req=%b addr=%0d, want req=0 addr=%0d", gray_req, gray_addr, exp_a);
        end
      end
      if (gray_req) begin
        rd_q.push_back(gray_addr);
        nreads++;
      end
      if (win_valid) break;
      @(negedge clk);
    end
    gray_ready = 1'b1;
    checks++;
    if (rd_q.size() != 9 || stall != 5) begin
      errors++;
      $display("FAIL wrap_reads: %0d reads, %0d stall cycles, want 9 and 5", rd_q.size(), stall);
    end
    for (int i = 0; i < 9 && i < rd_q.size(); i++) begin
      exp_a = (1 + i % 3) * IMG_W + (i / 3);
      checks++;
      if (rd_q[i] !== AW'(exp_a)) begin
        errors++;
        $display("FAIL wrap_read_addr[%0d]: got %0d, want %0d", i, rd_q[i], exp_a);
      end
    end
    checks++;
    if (win_valid !== 1'b1 || win_addr !== AW'(257) || win_data !== model_win(2, 1)) begin
      errors++;
      $display("FAIL wrap_window: valid=%b addr=%0d data=%h, want 1 257 %h",
               win_valid, win_addr, win_data, model_win(2, 1));
    end
  endtask

  task automatic test_full_frame();
    int edges, waits, nreads, nwin, cycles, finished;
    logic [AW-1:0]   last_addr;
    logic [WW-1:0]   exp_w;
    logic [AW-1:0]   exp_a;
    logic            prev_wait;
    logic [WW-1:0]   held;
    apply_reset();
    mem_rand();
    exp_q.delete();
    exp_rd_q.delete();
    for (int r = 1; r <= IMG_H - 2; r++) begin
      for (int c = 1; c <= IMG_W - 2; c++) begin
        if (c == 1) begin
          for (int col = 0; col < 3; col++)
            for (int row = 0; row < 3; row++)
              exp_rd_q.push_back(AW'((r - 1 + row) * IMG_W + col));
        end else begin
          for (int row = 0; row < 3; row++)
            exp_rd_q.push_back(AW'((r - 1 + row) * IMG_W + c + 1));
        end
        exp_q.push_back({AW'(r * IMG_W + c), model_win(r, c)});
      end
    end
    gray_ready = 1'b1;
    edges = 0; waits = 0; nreads = 0; nwin = 0; cycles = 0; finished = 0;
    last_addr = '0;
    prev_wait = 1'b0;
    held = '0;
    for (int n = 0; n < 90000; n++) begin
      win_ready = ($urandom_range(0, 7) != 0);
      #1;
      if (done) begin
        cycles = edges - 1;
        finished = 1;
        break;
      end
      if (gray_req) begin
        nreads++;
        exp_a = (exp_rd_q.size() != 0) ? exp_rd_q.pop_front() : '1;
        checks++;
        if (gray_addr !== exp_a || int'(gray_addr) >= NPIX) begin
          errors++;
          $display("FAIL frame_read[%0d]: got %0d, want %0d", nreads, gray_addr, exp_a);
        end
      end
      if (prev_wait) begin
        checks++;
        if (win_valid !== 1'b1 || {win_addr, win_data} !== held) begin
          errors++;
          $display("FAIL frame_hold: valid=%b addr=%0d, want valid=1 addr=%0d", win_valid, win_addr, held[WW-1 -: AW]);
        end
      end
      prev_wait = 1'b0;
      if (win_valid) begin
        if (win_ready) begin
          nwin++;
          last_addr = win_addr;
          exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
          checks++;
          if ({win_addr, win_data} !== exp_w) begin
            errors++;
            $display("FAIL frame_window[%0d]: got addr=%0d data=%h, want addr=%0d data=%h",
                     nwin, win_addr, win_data, exp_w[WW-1 -: AW], exp_w[9*DW-1:0]);
          end
        end else begin
          waits++;
          prev_wait = 1'b1;
          held = {win_addr, win_data};
        end
      end
      @(negedge clk);
      edges++;
    end
    win_ready = 1'b0;
    checks++;
    if (finished == 0) begin
      errors++;
      $display("FAIL frame_timeout: done=%b after %0d edges, want done=1", done, edges);
    end
    checks++;
    if (nwin != 15876 || nreads != 48384 || exp_q.size() != 0 || exp_rd_q.size() != 0) begin
      errors++;
      $display("FAIL frame_totals: windows=%0d reads=%0d, want 15876 48384", nwin, nreads);
    end
    checks++;
    if (last_addr !== AW'(16254)) begin
      errors++;
      $display("FAIL frame_last_addr: got %0d, want 16254", last_addr);
    end
    checks++;
    if (cycles != 64260 + waits) begin
      errors++;
      $display("FAIL frame_cycles: got %0d, want %0d", cycles, 64260 + waits);
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      gray_ready = 1'($urandom_range(0, 1));
      win_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (done !== 1'b1 || gray_req !== 1'b0 || win_valid !== 1'b0) begin
        errors++;
        $display("FAIL done_sticky[%0d]: done=%b req=%b valid=%b, want 1 0 0", n, done, gray_req, win_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_column_step();
    test_backpressure();
    test_row_wrap_stall();
    test_full_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
